// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA display controller:
//   - pixel-format encodings carried on mode_i
//   - the timing-configuration struct held in the shadow registers
//   - the colour-bar table used by the optional test pattern
// Timing fields are stored at CFG_W bits; the controller's CNT_WIDTH must not
// exceed CFG_W.
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam logic MODE_RGB888 = 1'b0;  // one pixel per 32-bit word
    localparam logic MODE_RGB565 = 1'b1;  // two pixels per word, low half first

    localparam int CFG_W = 16;

    typedef struct packed {
        logic [CFG_W-1:0] hvsize;
        logic [CFG_W-1:0] hfp;
        logic [CFG_W-1:0] hsync;
        logic [CFG_W-1:0] hbp;
        logic [CFG_W-1:0] vvsize;
        logic [CFG_W-1:0] vfp;
        logic [CFG_W-1:0] vsync;
        logic [CFG_W-1:0] vbp;
    } timing_cfg_t;

    // Bars left to right: white, yellow, cyan, green, magenta, red, blue, black.
    localparam logic [23:0] BAR_RGB [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/vga_pix_fifo.sv
// -----------------------------------------------------------------------------
// vga_pix_fifo
// Synchronous show-ahead FIFO for the pixel word stream.
//   clk_i, rst_i   clock, synchronous active-high reset (pointers/count)
//   flush_i        discards all contents on the next edge (wins over push/pop)
//   push_i/wdata_i write port; ignored when full
//   pop_i          advances the head; ignored when empty
//   rdata_o        head word, valid whenever cnt_o != 0
//   cnt_o          occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module vga_pix_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic [$clog2(DEPTH):0]   cnt_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, wptr_d;
    logic [AW-1:0]    rptr_q, rptr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push = push_i && (cnt_q != DEPTH_C);
        do_pop  = pop_i && (cnt_q != '0);
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + 1'b1;
            if (do_pop)  rptr_d = rptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset: only words covered by cnt_q are ever read.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush_i) mem_q[wptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rptr_q];
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/vga_disp_ctrl.sv
// -----------------------------------------------------------------------------
// vga_disp_ctrl
// VGA timing generator with a buffered pixel-word input stream.
//   clk_i, rst_i          clock, synchronous active-high reset
//   en_i                  display enable; low holds counters at 0, flushes FIFO
//   mode_i                0 = RGB888 (1 pixel/word), 1 = RGB565 (2 pixels/word)
//   h*/v* timing inputs   active size, front porch, sync width, back porch
//   hpol_i, vpol_i        sync polarity, 1 = active-high
//   pix_valid_i/pix_ready_o/pix_data_i   pixel word stream (valid/ready)
//   clr_i                 clears the sticky underflow flag
//   vga_*_o               registered colour, syncs, data enable
//   frame_start_o         one-cycle pulse aligned with pixel (0,0)
//   underflow_o           sticky: a pixel was needed while the FIFO was empty
//   fifo_cnt_o            FIFO occupancy
// Optional feature macro: VGA_TEST_PATTERN_EN adds input pattern_i, which
// replaces active pixels by eight vertical colour bars without touching the FIFO.
// DATA_WIDTH must be 32; CNT_WIDTH must not exceed vga_pkg::CFG_W.
// -----------------------------------------------------------------------------
module vga_disp_ctrl
    import vga_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 64,
    parameter int CNT_WIDTH  = 12
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic                          mode_i,
    input  logic [CNT_WIDTH-1:0]          hvsize_i,
    input  logic [CNT_WIDTH-1:0]          hfp_i,
    input  logic [CNT_WIDTH-1:0]          hsync_i,
    input  logic [CNT_WIDTH-1:0]          hbp_i,
    input  logic [CNT_WIDTH-1:0]          vvsize_i,
    input  logic [CNT_WIDTH-1:0]          vfp_i,
    input  logic [CNT_WIDTH-1:0]          vsync_i,
    input  logic [CNT_WIDTH-1:0]          vbp_i,
    input  logic                          hpol_i,
    input  logic                          vpol_i,
    input  logic                          pix_valid_i,
    output logic                          pix_ready_o,
    input  logic [DATA_WIDTH-1:0]         pix_data_i,
    input  logic                          clr_i,
`ifdef VGA_TEST_PATTERN_EN
    input  logic                          pattern_i,
`endif
    output logic [7:0]                    vga_r_o,
    output logic [7:0]                    vga_g_o,
    output logic [7:0]                    vga_b_o,
    output logic                          vga_hsync_o,
    output logic                          vga_vsync_o,
    output logic                          vga_de_o,
    output logic                          frame_start_o,
    output logic                          underflow_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FCW-1:0] DEPTH_C = FCW'(FIFO_DEPTH);

    // RGB565 -> RGB888 by replicating each field's MSBs into the new LSBs.
    function automatic logic [23:0] expand565(input logic [15:0] px);
        return {px[15:11], px[15:13], px[10:5], px[10:9], px[4:0], px[4:2]};
    endfunction

    timing_cfg_t cfg_in, cfg_q, cfg_d, cfg_eff;
    logic        en_q, en_d, en_rise;

    logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [CNT_WIDTH-1:0] h_vs, h_ss, h_se, h_tot;
    logic [CNT_WIDTH-1:0] v_vs, v_ss, v_se, v_tot;
    logic                 h_last, v_last, frame_wrap;
    logic                 active, hs_act, vs_act;

    logic                  half_q, half_d;
    logic                  underflow_q, underflow_d;
    logic [7:0]            r_q, g_q, b_q;
    logic [23:0]           rgb_d;
    logic                  hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic                  uf_evt, pop;

    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic [FCW-1:0]        fifo_cnt;
    logic                  fifo_empty, push;

    assign cfg_in = '{
        hvsize: CFG_W'(hvsize_i), hfp: CFG_W'(hfp_i),
        hsync:  CFG_W'(hsync_i),  hbp: CFG_W'(hbp_i),
        vvsize: CFG_W'(vvsize_i), vfp: CFG_W'(vfp_i),
        vsync:  CFG_W'(vsync_i),  vbp: CFG_W'(vbp_i)
    };

    // Timing and counters. On the enable edge the shadow registers are loaded
    // in the same cycle that pixel (0,0) is evaluated, so that cycle must see
    // the live inputs rather than the stale shadow contents.
    always_comb begin
        en_rise = en_i && !en_q;
        en_d    = en_i;
        cfg_eff = en_rise ? cfg_in : cfg_q;

        h_vs  = CNT_WIDTH'(cfg_eff.hvsize);
        h_ss  = h_vs + CNT_WIDTH'(cfg_eff.hfp);
        h_se  = h_ss + CNT_WIDTH'(cfg_eff.hsync);
        h_tot = h_se + CNT_WIDTH'(cfg_eff.hbp);
        v_vs  = CNT_WIDTH'(cfg_eff.vvsize);
        v_ss  = v_vs + CNT_WIDTH'(cfg_eff.vfp);
        v_se  = v_ss + CNT_WIDTH'(cfg_eff.vsync);
        v_tot = v_se + CNT_WIDTH'(cfg_eff.vbp);

        h_last     = (hcnt_q == h_tot - 1'b1);
        v_last     = (vcnt_q == v_tot - 1'b1);
        frame_wrap = en_i && h_last && v_last;
        cfg_d      = (en_rise || frame_wrap) ? cfg_in : cfg_q;

        hcnt_d = '0;
        vcnt_d = '0;
        if (en_i) begin
            hcnt_d = h_last ? '0 : hcnt_q + 1'b1;
            vcnt_d = vcnt_q;
            if (h_last) vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
        end

        active = en_i && (hcnt_q < h_vs) && (vcnt_q < v_vs);
        hs_act = en_i && (hcnt_q >= h_ss) && (hcnt_q < h_se);
        vs_act = en_i && (vcnt_q >= v_ss) && (vcnt_q < v_se);
    end

`ifdef VGA_TEST_PATTERN_EN
    logic [CNT_WIDTH-1:0] bar_w, bar_raw;
    logic [2:0]           bar_idx;

    // Bar width is hvsize/8; anything right of the eighth bar stays black.
    always_comb begin
        bar_w   = h_vs >> 3;
        bar_raw = (bar_w == '0) ? '0 : hcnt_q / bar_w;
        bar_idx = (|bar_raw[CNT_WIDTH-1:3]) ? 3'd7 : bar_raw[2:0];
    end
`endif

    // Pixel fetch. In RGB565 the head word stays in the FIFO while its low
    // half is shown and is popped with the high half, so a pending half-word
    // always has data behind it and never underflows.
    always_comb begin
        fifo_empty = (fifo_cnt == '0);
        pop        = 1'b0;
        uf_evt     = 1'b0;
        half_d     = half_q;
        rgb_d      = 24'h0;
        if (!en_i) begin
            half_d = 1'b0;
        end else if (active) begin
`ifdef VGA_TEST_PATTERN_EN
            if (pattern_i) begin
                rgb_d = BAR_RGB[bar_idx];
            end else
`endif
            if (mode_i == MODE_RGB565) begin
                if (half_q) begin
                    rgb_d  = expand565(fifo_rdata[31:16]);
                    pop    = 1'b1;
                    half_d = 1'b0;
                end else if (fifo_empty) begin
                    uf_evt = 1'b1;
                end else begin
                    rgb_d  = expand565(fifo_rdata[15:0]);
                    half_d = 1'b1;
                end
            end else begin
                half_d = 1'b0;
                if (fifo_empty) begin
                    uf_evt = 1'b1;
                end else begin
                    rgb_d = fifo_rdata[23:0];
                    pop   = 1'b1;
                end
            end
        end

        underflow_d = uf_evt ? 1'b1 : (clr_i ? 1'b0 : underflow_q);
        de_d        = active;
        fs_d        = en_i && (hcnt_q == '0) && (vcnt_q == '0);
        hs_d        = ~(hs_act ^ hpol_i);
        vs_d        = ~(vs_act ^ vpol_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_q        <= 1'b0;
            cfg_q       <= '0;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            half_q      <= 1'b0;
            underflow_q <= 1'b0;
            r_q         <= '0;
            g_q         <= '0;
            b_q         <= '0;
            de_q        <= 1'b0;
            fs_q        <= 1'b0;
            hs_q        <= ~hpol_i;
            vs_q        <= ~vpol_i;
        end else begin
            en_q        <= en_d;
            cfg_q       <= cfg_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            half_q      <= half_d;
            underflow_q <= underflow_d;
            r_q         <= rgb_d[23:16];
            g_q         <= rgb_d[15:8];
            b_q         <= rgb_d[7:0];
            de_q        <= de_d;
            fs_q        <= fs_d;
            hs_q        <= hs_d;
            vs_q        <= vs_d;
        end
    end

    // Pop decisions use the occupancy before this cycle's push, so a word
    // arriving into an empty FIFO is stored, never bypassed to the display.
    assign pix_ready_o = en_i && (fifo_cnt < DEPTH_C);
    assign push        = pix_valid_i && pix_ready_o;

    vga_pix_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (~en_i),
        .push_i  (push),
        .wdata_i (pix_data_i),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .cnt_o   (fifo_cnt)
    );

    assign vga_r_o       = r_q;
    assign vga_g_o       = g_q;
    assign vga_b_o       = b_q;
    assign vga_hsync_o   = hs_q;
    assign vga_vsync_o   = vs_q;
    assign vga_de_o      = de_q;
    assign frame_start_o = fs_q;
    assign underflow_o   = underflow_q;
    assign fifo_cnt_o    = fifo_cnt;

endmodule
